// File: rtl/sv32_tlb_pkg.sv
// Shared Sv32 TLB types: PTE layout, walker fill request and per-entry storage.
package sv32_tlb_pkg;

   localparam int unsigned SV32_PAGE_OFFSET_W = 12;
   localparam int unsigned SV32_VPN_W         = 10;
   localparam int unsigned SV32_ASID_W        = 1;

   typedef struct packed {
      logic [21:0] ppn;
      logic [1:0]  rsw;
      logic        d;
      logic        a;
      logic        g;
      logic        u;
      logic        x;
      logic        w;
      logic        r;
      logic        v;
   } pte_t;

   typedef struct packed {
      logic                    valid;
      logic                    is_4M;
      logic [2*SV32_VPN_W-1:0] vpn;
      logic [SV32_ASID_W-1:0]  asid;
      pte_t                    content;
   } tlb_update_t;

   typedef struct packed {
      logic                   valid;
      logic                   is_4M;
      logic [SV32_VPN_W-1:0]  vpn1;
      logic [SV32_VPN_W-1:0]  vpn0;
      logic [SV32_ASID_W-1:0] asid;
      pte_t                   pte;
   } tlb_entry_t;

endpackage

// File: rtl/tlb_plru_tree.sv
// Tree pseudo-LRU replacement state for a power-of-two number of ways.
module tlb_plru_tree #(
   parameter int unsigned ENTRIES = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       touch_valid_i,
   input  logic [$clog2(ENTRIES)-1:0] touch_idx_i,
   output logic [$clog2(ENTRIES)-1:0] victim_idx_o
);

   localparam int unsigned IdxW = $clog2(ENTRIES);

   // Heap-ordered nodes 1..ENTRIES-1; level l selects index bit l (LSB at the root).
   logic [ENTRIES-1:1] tree_q, tree_d;
   logic [IdxW-1:0]    touch_node, victim_node, victim;

   always_comb begin
      tree_d     = tree_q;
      touch_node = '0;
      if (touch_valid_i) begin
         for (int unsigned l = 0; l < IdxW; l++) begin
            touch_node         = IdxW'(1 << l) | (touch_idx_i & IdxW'((1 << l) - 1));
            tree_d[touch_node] = ~1'(touch_idx_i >> l);
         end
      end
   end

   always_comb begin
      victim      = '0;
      victim_node = '0;
      for (int unsigned l = 0; l < IdxW; l++) begin
         victim_node = IdxW'(1 << l) | victim;
         victim      = victim | (IdxW'(tree_q[victim_node]) << l);
      end
   end

   assign victim_idx_o = victim;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tree_q <= '0;
      end else begin
         tree_q <= tree_d;
      end
   end

endmodule

// File: rtl/sv32_tlb.sv
// Fully-associative Sv32 TLB with zero-latency lookup and PLRU refill.
// Define SV32_TLB_SFENCE_SEL_EN for ASID/vaddr-selective sfence.vma flushes.
module sv32_tlb
   import sv32_tlb_pkg::*;
#(
   parameter int unsigned TLB_ENTRIES = 4,
   parameter int unsigned ASID_WIDTH  = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
`ifdef SV32_TLB_SFENCE_SEL_EN
   input  logic [ASID_WIDTH-1:0] flush_asid_i,
   input  logic [31:0]           flush_vaddr_i,
`endif
   input  tlb_update_t           update_i,
   input  logic                  lu_access_i,
   input  logic [ASID_WIDTH-1:0] lu_asid_i,
   input  logic [31:0]           lu_vaddr_i,
   output logic                  lu_hit_o,
   output pte_t                  lu_content_o,
   output logic                  lu_is_4M_o,
   output logic [33:0]           lu_paddr_o
);

   localparam int unsigned IdxW = $clog2(TLB_ENTRIES);

   tlb_entry_t             entry_q [TLB_ENTRIES];
   tlb_entry_t             entry_d [TLB_ENTRIES];
   tlb_entry_t             hit_entry;
   logic [TLB_ENTRIES-1:0] match, flush_sel;
   logic [IdxW-1:0]        hit_idx, inv_idx, plru_idx, victim_idx, touch_idx;
   logic                   hit_found, inv_found, fill_en, touch_valid;

   always_comb begin
      match     = '0;
      hit_idx   = '0;
      inv_idx   = '0;
      hit_found = 1'b0;
      inv_found = 1'b0;
      for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
         match[i] = entry_q[i].valid
                  & (entry_q[i].pte.g | (ASID_WIDTH'(entry_q[i].asid) == lu_asid_i))
                  & (entry_q[i].vpn1 == lu_vaddr_i[31:22])
                  & (entry_q[i].is_4M | (entry_q[i].vpn0 == lu_vaddr_i[21:12]));
         if (match[i] && !hit_found) begin
            hit_found = 1'b1;
            hit_idx   = IdxW'(i);
         end
         if (!entry_q[i].valid && !inv_found) begin
            inv_found = 1'b1;
            inv_idx   = IdxW'(i);
         end
      end
   end

   assign hit_entry = entry_q[hit_idx];
   assign lu_hit_o  = lu_access_i & hit_found;

   always_comb begin
      lu_content_o = '0;
      lu_is_4M_o   = 1'b0;
      lu_paddr_o   = '0;
      if (lu_hit_o) begin
         lu_content_o = hit_entry.pte;
         lu_is_4M_o   = hit_entry.is_4M;
         lu_paddr_o   = hit_entry.is_4M ? {hit_entry.pte.ppn[21:10], lu_vaddr_i[21:0]}
                                        : {hit_entry.pte.ppn, lu_vaddr_i[11:0]};
      end
   end

`ifdef SV32_TLB_SFENCE_SEL_EN
   // Zero selectors act as wildcards, as in sfence.vma rs1/rs2 = x0.
   always_comb begin
      flush_sel = '0;
      for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
         flush_sel[i] = ((flush_vaddr_i == '0)
                         | ((entry_q[i].vpn1 == flush_vaddr_i[31:22])
                            & (entry_q[i].is_4M | (entry_q[i].vpn0 == flush_vaddr_i[21:12]))))
                      & ((flush_asid_i == '0)
                         | (~entry_q[i].pte.g & (ASID_WIDTH'(entry_q[i].asid) == flush_asid_i)));
      end
   end
`else
   assign flush_sel = '1;
`endif

   assign fill_en     = update_i.valid & ~flush_i;
   assign victim_idx  = inv_found ? inv_idx : plru_idx;
   // A fill in the same cycle as a hit owns the tree update.
   assign touch_valid = fill_en | lu_hit_o;
   assign touch_idx   = fill_en ? victim_idx : hit_idx;

   always_comb begin
      entry_d = entry_q;
      if (flush_i) begin
         for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
            if (flush_sel[i]) begin
               entry_d[i].valid = 1'b0;
            end
         end
      end else if (update_i.valid) begin
         entry_d[victim_idx] = '{valid: 1'b1,
                                 is_4M: update_i.is_4M,
                                 vpn1:  update_i.vpn[19:10],
                                 vpn0:  update_i.vpn[9:0],
                                 asid:  update_i.asid,
                                 pte:   update_i.content};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         entry_q <= '{default: '0};
      end else begin
         entry_q <= entry_d;
      end
   end

   tlb_plru_tree #(
      .ENTRIES(TLB_ENTRIES)
   ) u_plru (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .touch_valid_i(touch_valid),
      .touch_idx_i  (touch_idx),
      .victim_idx_o (plru_idx)
   );

endmodule

// File: tb/tb_sv32_tlb.sv
// Scoreboard bench for sv32_tlb: expected lookups are queued at drive time, checked at negedge.
module tb_sv32_tlb;
   import sv32_tlb_pkg::*;

   localparam int unsigned Entries = 4;
   localparam int unsigned AsidW   = 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              flush;
   logic [AsidW-1:0]  flush_asid;
   logic [31:0]       flush_vaddr;
   tlb_update_t       update;
   logic              lu_access;
   logic [AsidW-1:0]  lu_asid;
   logic [31:0]       lu_vaddr;
   logic              lu_hit;
   pte_t              lu_content;
   logic              lu_is_4m;
   logic [33:0]       lu_paddr;

   typedef struct {
      string       tag;
      logic        hit;
      logic        is4m;
      logic [33:0] pa;
      logic [31:0] ct;
   } exp_t;

   exp_t        sb[$];
   int unsigned total = 0;
   int unsigned bad   = 0;

   always #5 clk = ~clk;

   sv32_tlb #(
      .TLB_ENTRIES(Entries),
      .ASID_WIDTH (AsidW)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .flush_i      (flush),
`ifdef SV32_TLB_SFENCE_SEL_EN
      .flush_asid_i (flush_asid),
      .flush_vaddr_i(flush_vaddr),
`endif
      .update_i     (update),
      .lu_access_i  (lu_access),
      .lu_asid_i    (lu_asid),
      .lu_vaddr_i   (lu_vaddr),
      .lu_hit_o     (lu_hit),
      .lu_content_o (lu_content),
      .lu_is_4M_o   (lu_is_4m),
      .lu_paddr_o   (lu_paddr)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic pte_t mk_pte(input logic [21:0] ppn, input logic g);
      pte_t p;
      p     = '0;
      p.ppn = ppn;
      p.a   = 1'b1;
      p.g   = g;
      p.r   = 1'b1;
      p.v   = 1'b1;
      return p;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && lu_access) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 64'(1), 64'(0));
         end else begin
            e = sb.pop_front();
            check({e.tag, "_hit"}, 64'(lu_hit), 64'(e.hit));
            check({e.tag, "_4m"}, 64'(lu_is_4m), 64'(e.is4m));
            check({e.tag, "_pa"}, 64'(lu_paddr), 64'(e.pa));
            check({e.tag, "_pte"}, 64'(lu_content), 64'(e.ct));
         end
      end
   end

   task automatic set_fill(input logic [19:0] vpn, input logic is4m, input logic [21:0] ppn,
                           input logic g, input logic [AsidW-1:0] asid);
      update.valid   = 1'b1;
      update.is_4M   = is4m;
      update.vpn     = vpn;
      update.asid    = asid;
      update.content = mk_pte(ppn, g);
   endtask

   task automatic set_lookup(input string tag, input logic [AsidW-1:0] asid,
                             input logic [31:0] va, input logic hit, input logic is4m,
                             input logic [21:0] ppn, input logic g);
      exp_t e;
      lu_access = 1'b1;
      lu_asid   = asid;
      lu_vaddr  = va;
      e.tag     = tag;
      e.hit     = hit;
      e.is4m    = hit & is4m;
      e.ct      = hit ? mk_pte(ppn, g) : '0;
      e.pa      = !hit ? '0 : is4m ? {ppn[21:10], va[21:0]} : {ppn, va[11:0]};
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      update      = '0;
      lu_access   = 1'b0;
      flush       = 1'b0;
      flush_asid  = '0;
      flush_vaddr = '0;
   endtask

   initial begin
      rst_n       = 1'b0;
      flush       = 1'b0;
      flush_asid  = '0;
      flush_vaddr = '0;
      update      = '0;
      lu_access   = 1'b0;
      lu_asid     = '0;
      lu_vaddr    = '0;
      repeat (2) @(posedge clk);
      #1;
      lu_access = 1'b1;
      lu_vaddr  = 32'h0040_1234;
      @(negedge clk);
      check("rst_hit", 64'(lu_hit), 64'(0));
      check("rst_pa", 64'(lu_paddr), 64'(0));
      check("rst_pte", 64'(lu_content), 64'(0));
      lu_access = 1'b0;
      rst_n     = 1'b1;
      step();

      set_lookup("post_rst", 1'b0, 32'h0040_1234, 1'b0, 1'b0, '0, 1'b0);
      step();
      set_fill(20'h00401, 1'b0, 22'h012345, 1'b0, 1'b1);
      set_lookup("fill_cycle", 1'b1, 32'h0040_1ABC, 1'b0, 1'b0, '0, 1'b0);
      step();
      set_lookup("hit4k", 1'b1, 32'h0040_1ABC, 1'b1, 1'b0, 22'h012345, 1'b0);
      step();
      set_lookup("asid_miss", 1'b0, 32'h0040_1ABC, 1'b0, 1'b0, '0, 1'b0);
      step();
      set_fill(20'hFFC00, 1'b1, 22'h0AB000, 1'b1, 1'b1);
      step();
      set_lookup("hit4m_glob", 1'b0, 32'hFFC1_2345, 1'b1, 1'b1, 22'h0AB000, 1'b1);
      step();
      lu_access = 1'b0;
      lu_vaddr  = 32'hFFC1_2345;
      @(negedge clk);
      check("no_access_hit", 64'(lu_hit), 64'(0));
      step();

      // PLRU: A..D fill entries 0..3, A re-touched, E must replace B.
      flush = 1'b1;
      step();
      for (int k = 1; k <= 4; k++) begin
         set_fill(20'(k << 16), 1'b0, 22'(k << 8), 1'b0, 1'b0);
         step();
      end
      set_lookup("plru_touch_a", 1'b0, 32'h1000_0010, 1'b1, 1'b0, 22'h000100, 1'b0);
      step();
      set_fill(20'h50000, 1'b0, 22'h000500, 1'b0, 1'b0);
      step();
      set_lookup("evict_b", 1'b0, 32'h2000_0020, 1'b0, 1'b0, '0, 1'b0);
      step();
      set_lookup("keep_a", 1'b0, 32'h1000_0FFF, 1'b1, 1'b0, 22'h000100, 1'b0);
      step();
      set_lookup("keep_c", 1'b0, 32'h3000_0030, 1'b1, 1'b0, 22'h000300, 1'b0);
      step();
      set_lookup("keep_d", 1'b0, 32'h4000_0040, 1'b1, 1'b0, 22'h000400, 1'b0);
      step();
      set_lookup("new_e", 1'b0, 32'h5000_0050, 1'b1, 1'b0, 22'h000500, 1'b0);
      step();

      // Asynchronous reset while a fill is pending.
      set_fill(20'h70000, 1'b0, 22'h000700, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      set_lookup("rst_fill_g", 1'b0, 32'h7000_0000, 1'b0, 1'b0, '0, 1'b0);
      step();
      set_lookup("rst_clr_a", 1'b0, 32'h1000_0000, 1'b0, 1'b0, '0, 1'b0);
      step();

      // Flush beats a same-cycle fill; lookup in that cycle still sees old contents.
      set_fill(20'h10000, 1'b0, 22'h000100, 1'b0, 1'b0);
      step();
      set_fill(20'h60000, 1'b0, 22'h000600, 1'b0, 1'b0);
      flush = 1'b1;
      set_lookup("flush_cycle", 1'b0, 32'h1000_0000, 1'b1, 1'b0, 22'h000100, 1'b0);
      step();
      set_lookup("flush_drop_f", 1'b0, 32'h6000_0000, 1'b0, 1'b0, '0, 1'b0);
      step();
      set_lookup("flush_a", 1'b0, 32'h1000_0000, 1'b0, 1'b0, '0, 1'b0);
      step();

`ifdef SV32_TLB_SFENCE_SEL_EN
      set_fill(20'h11111, 1'b0, 22'h000111, 1'b0, 1'b1);
      step();
      set_fill(20'h22222, 1'b0, 22'h000222, 1'b1, 1'b1);
      step();
      set_fill(20'h33333, 1'b0, 22'h000333, 1'b0, 1'b0);
      step();
      flush      = 1'b1;
      flush_asid = 1'b1;
      step();
      set_lookup("sel_nonglob", 1'b1, 32'h1111_1000, 1'b0, 1'b0, '0, 1'b0);
      step();
      set_lookup("sel_glob", 1'b1, 32'h2222_2000, 1'b1, 1'b0, 22'h000222, 1'b1);
      step();
      set_lookup("sel_other", 1'b0, 32'h3333_3000, 1'b1, 1'b0, 22'h000333, 1'b0);
      step();
`endif

      step();
      check("sb_drained", 64'(sb.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
